aes_round_sequencer: RTL

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 110 +++++++++++
 1 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption sequencer. It drives an external round datapath and an external key store,
// and keeps one block in flight through the initial AddRoundKey plus NUM_ROUNDS rounds.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [127:0] rnd_state,
  output logic         rnd_final,
  input  logic [127:0] rnd_result,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ROUND = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t       state_reg;
  logic [3:0]   round_cnt_reg;
  logic [3:0]   round_cnt_next;
  logic [127:0] data_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         busy_reg;
  logic         rnd_final_reg;
  logic [3:0]   rk_idx_reg;

  assign round_cnt_next = round_cnt_reg + 4'd1;

  // Every output is a flop updated together with the state, so each one
  // is loaded with the value that belongs to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      round_cnt_reg <= 4'd0;
      data_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      rk_idx_reg    <= 4'd0;
      rnd_final_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            state_reg     <= ROUND;
            data_reg      <= in_block ^ rk_data;
            round_cnt_reg <= 4'd1;
            rk_idx_reg    <= 4'd1;
            rnd_final_reg <= (LAST_ROUND == 4'd1);
            in_ready_reg  <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        ROUND: begin
          data_reg <= rnd_result;
          if (round_cnt_reg < LAST_ROUND) begin
            round_cnt_reg <= round_cnt_next;
            rk_idx_reg    <= round_cnt_next;
            rnd_final_reg <= (round_cnt_next == LAST_ROUND);
          end else begin
            // The counter stays at the final round so it never wraps.
            state_reg     <= DONE;
            rk_idx_reg    <= 4'd0;
            rnd_final_reg <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          round_cnt_reg <= 4'd0;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          rk_idx_reg    <= 4'd0;
          rnd_final_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign rk_idx    = rk_idx_reg;
  assign rnd_final = rnd_final_reg;
  assign rnd_state = data_reg;
  assign out_block = data_reg;

endmodule
